lcd1602_responder: RTL and testbench
====================================

LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

Interface
REQ-001 CLEAR_CYCLES, 153000, busy duration in clk cycles after clear or return-home.
REQ-002 EXEC_CYCLES, 3700, busy duration after any other accepted write byte.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 lcd_e  input  1  host enable strobe, asynchronous to clk.
REQ-006 lcd_rs  input  1  register select: 0 instruction, 1 data.
REQ-007 lcd_rw  input  1  1 read, 0 write.
REQ-008 lcd_d  input  4  host data nibble, pins D7..D4.
REQ-009 row_a  output  128  DDRAM 0x00-0x0F; char 0 in [127:120].
REQ-010 row_b  output  128  DDRAM 0x40-0x4F, same packing.
REQ-011 ac  output  7  address counter.
REQ-012 mode4  output  1  1 = 4-bit interface active.
REQ-013 display_on  output  1  display-control D bit.
REQ-014 cursor_incr  output  1  entry-mode I/D bit.
REQ-015 busy  output  1  command execution in progress.
REQ-016 overrun  output  1  sticky: write byte arrived while busy.
REQ-017 cmd_valid  output  1  one-cycle pulse per completed write byte.
REQ-018 cmd_rs  output  1  RS of last completed write byte.
REQ-019 cmd_byte  output  8  last completed write byte.
REQ-020 lcd_dout  output  4  read-back nibble.
REQ-021 lcd_doe  output  1  read-back drive enable.

Function
REQ-022 lcd_e/rs/rw/d SHALL pass a 2-flop synchronizer; a transfer is a falling edge of synchronized E, sampling rs/rw/d from the same stage.
REQ-023 lcd_e first sampled low at edge k SHALL produce all state updates at edge k+2; cmd_valid high only in the cycle after k+2.
REQ-024 8-bit mode (mode4=0): each write transfer SHALL form byte {lcd_d,4'h0}, decoded normally.
REQ-025 4-bit mode: phase flag SHALL toggle on every transfer (reads included); high nibble first, byte completes on low nibble using that transfer's RS/RW.
REQ-026 Decode by highest set bit: 1aaaaaaa set AC; 01xxxxxx no-op; 001Dxxxx mode4<=~D, phase<=high; 0001xxxx no-op; 00001Dxx display_on<=D; 000001Ix cursor_incr<=I; 0000001x AC<=0; 00000001 rows<=all 0x20, AC<=0, cursor_incr<=1.
REQ-027 Set-AC values 0x28-0x3F SHALL load 0x40; 0x68-0x7F SHALL load 0x00.
REQ-028 Data write SHALL store at AC when AC in 0x00-0x0F/0x40-0x4F (else discarded), then advance AC.
REQ-029 AC wrap: increment 0x27->0x40, 0x67->0x00; decrement 0x00->0x67, 0x40->0x27.
REQ-030 Accepted write byte SHALL load busy counter (CLEAR_CYCLES for clear/home, else EXEC_CYCLES), decrement per cycle; busy = counter!=0.
REQ-031 Byte completing while busy SHALL be discarded, set overrun, still pulse cmd_valid, not reload counter.
REQ-032 Read transfers SHALL change no state except phase and read AC advance (REQ-036); no cmd_valid.

Reset
REQ-033 Reset SHALL set rows all 0x20, ac=0, mode4=0, phase=high, display_on=0, cursor_incr=1, busy counter=0, overrun=0, cmd_valid=0, cmd_rs=0, cmd_byte=0, lcd_doe=0, lcd_dout=0, synchronizer flops 0.
REQ-034 Reset mid-byte or mid-busy SHALL abort it; the first post-reset transfer is a high nibble in 8-bit mode.

Configuration
REQ-035 Macro LCD_RESP_READ_EN defined: while synchronized E=1 and RW=1, lcd_doe=1; RS=0 drives {busy,ac[6:4]} (high phase) or ac[3:0] (low phase); RS=1 drives the DDRAM nibble at AC (0x20 if not visible).
REQ-036 With macro: RS=1 read SHALL advance AC per REQ-029 on the low-nibble transfer. Without macro: lcd_doe=0, lcd_dout=0 always, reads never move AC.

Verification
REQ-037 Reset; nibbles 3,3,3,2 -> mode4=1 after 4th transfer, cmd_byte=0x20, four cmd_valid pulses.
REQ-038 4-bit: 0x80, then data 0x41,0x42 (waiting out busy) -> row_a[127:112]=0x4142, ac=0x02.
REQ-039 Set AC 0x27, write 0x5A -> not stored, ac=0x40; decrement mode at 0x00 -> ac=0x67.
REQ-040 Clear 0x01 then data write 100 cycles later -> write discarded, overrun=1, row_a all 0x20, busy until CLEAR_CYCLES elapsed.
REQ-041 READ_EN: AC=0x45 idle, RS=0 read -> lcd_dout 0x4 then 0x5; RS=1 read at AC=0x40 after 'Q' stored -> 0x5,0x1, ac=0x41.

Source files
------------

// File: rtl/lcd1602_responder.sv
// ---------------------------------------------------------------------------
// lcd1602_responder
//
// Behavioural stand-in for an HD44780-style 16x2 character LCD controller,
// seen from the host side of its parallel bus. The host drives E/RS/RW/D7..D4
// asynchronously to clk; every falling edge of the synchronised E is one
// transfer. Write bytes are decoded like the real controller: instruction set,
// DDRAM writes through the address counter, and busy timing. Only the two
// visible 16-character windows of DDRAM are stored.
//
// Optional feature: define LCD_RESP_READ_EN to enable host read-back
// (busy flag / address counter and DDRAM contents on lcd_dout). Without it
// the read-back outputs stay at zero and reads never move the address counter.
//
// Parameters
//   CLEAR_CYCLES  busy duration after clear display or return home
//   EXEC_CYCLES   busy duration after any other accepted write byte
//
// Ports
//   clk          system clock (100 MHz)
//   reset        synchronous, active-high reset
//   lcd_e        host enable strobe (asynchronous)
//   lcd_rs       register select: 0 instruction, 1 data
//   lcd_rw       1 read, 0 write
//   lcd_d        host data nibble, pins D7..D4
//   row_a        DDRAM 0x00-0x0F, character 0 in [127:120]
//   row_b        DDRAM 0x40-0x4F, same packing
//   ac           address counter
//   mode4        1 when the 4-bit interface is active
//   display_on   display-control D bit
//   cursor_incr  entry-mode I/D bit
//   busy         command execution in progress
//   overrun      sticky flag: a write byte arrived while busy
//   cmd_valid    one-cycle pulse per completed write byte
//   cmd_rs       RS of the last completed write byte
//   cmd_byte     last completed write byte
//   lcd_dout     read-back nibble
//   lcd_doe      read-back drive enable
// ---------------------------------------------------------------------------
module lcd1602_responder #(
   parameter int CLEAR_CYCLES = 153000,
   parameter int EXEC_CYCLES  = 3700
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         lcd_e,
   input  logic         lcd_rs,
   input  logic         lcd_rw,
   input  logic [3:0]   lcd_d,
   output logic [127:0] row_a,
   output logic [127:0] row_b,
   output logic [6:0]   ac,
   output logic         mode4,
   output logic         display_on,
   output logic         cursor_incr,
   output logic         busy,
   output logic         overrun,
   output logic         cmd_valid,
   output logic         cmd_rs,
   output logic [7:0]   cmd_byte,
   output logic [3:0]   lcd_dout,
   output logic         lcd_doe
);

   localparam int MAX_CYCLES = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
   localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYCLES);
   localparam logic [127:0]     BLANK_ROW  = {16{8'h20}};

   // Which nibble of a 4-bit byte the next transfer carries
   typedef enum logic {PH_HIGH, PH_LOW} phase_t;

   logic             e_s1, e_s2, e_d;
   logic             rs_s1, rs_s2;
   logic             rw_s1, rw_s2;
   logic [3:0]       d_s1, d_s2;
   phase_t           phase;
   logic [3:0]       hi_nib;
   logic [CNT_W-1:0] busy_cnt;
   logic             xfer;
   logic             low_phase;
   logic             byte_done;
   logic [7:0]       new_byte;

   // Set-AC targets in the hole between the two DDRAM lines snap to the
   // start of the next line, mirroring how the real part folds its address map.
   function automatic logic [6:0] set_ac_value(input logic [6:0] a);
      logic [6:0] n;
      if (a >= 7'h28 && a <= 7'h3F)
         n = 7'h40;
      else if (a >= 7'h68)
         n = 7'h00;
      else
         n = a;
      return n;
   endfunction

   // Address counter moves through 0x00-0x27 and 0x40-0x67 as one ring.
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic incr);
      logic [6:0] n;
      if (incr) begin
         if (a == 7'h27)
            n = 7'h40;
         else if (a == 7'h67)
            n = 7'h00;
         else
            n = a + 7'd1;
      end else begin
         if (a == 7'h00)
            n = 7'h67;
         else if (a == 7'h40)
            n = 7'h27;
         else
            n = a - 7'd1;
      end
      return n;
   endfunction

   // Only the first 16 cells of each line are kept.
   function automatic logic ac_visible(input logic [6:0] a);
      return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
   endfunction

   // Two-flop synchroniser on every host pin, plus a delayed copy of E so
   // the falling edge is seen on the same stage that rs/rw/d are taken from.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_s1  <= 1'b0;
         e_s2  <= 1'b0;
         e_d   <= 1'b0;
         rs_s1 <= 1'b0;
         rs_s2 <= 1'b0;
         rw_s1 <= 1'b0;
         rw_s2 <= 1'b0;
         d_s1  <= 4'h0;
         d_s2  <= 4'h0;
      end else begin
         e_s1  <= lcd_e;
         e_s2  <= e_s1;
         e_d   <= e_s2;
         rs_s1 <= lcd_rs;
         rs_s2 <= rs_s1;
         rw_s1 <= lcd_rw;
         rw_s2 <= rw_s1;
         d_s1  <= lcd_d;
         d_s2  <= d_s1;
      end
   end

   // Transfer detection and byte assembly. In 8-bit mode only D7..D4 are
   // wired, so the low nibble of each byte reads as zero.
   always_comb begin
      xfer      = e_d & ~e_s2;
      low_phase = mode4 && (phase == PH_LOW);
      byte_done = 1'b0;
      new_byte  = 8'h00;
      if (xfer && !rw_s2) begin
         if (!mode4) begin
            byte_done = 1'b1;
            new_byte  = {d_s2, 4'h0};
         end else if (low_phase) begin
            byte_done = 1'b1;
            new_byte  = {hi_nib, d_s2};
         end
      end
   end

   assign busy = (busy_cnt != '0);

   // Controller state: nibble phase, instruction decode, DDRAM writes and the
   // busy timer. A byte that lands while busy is reported but not executed.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_a       <= BLANK_ROW;
         row_b       <= BLANK_ROW;
         ac          <= 7'h00;
         mode4       <= 1'b0;
         phase       <= PH_HIGH;
         hi_nib      <= 4'h0;
         display_on  <= 1'b0;
         cursor_incr <= 1'b1;
         busy_cnt    <= '0;
         overrun     <= 1'b0;
         cmd_valid   <= 1'b0;
         cmd_rs      <= 1'b0;
         cmd_byte    <= 8'h00;
      end else begin
         cmd_valid <= byte_done;
         if (busy_cnt != '0)
            busy_cnt <= busy_cnt - 1'b1;

         if (xfer && mode4) begin
            if (phase == PH_HIGH) begin
               hi_nib <= d_s2;
               phase  <= PH_LOW;
            end else begin
               phase  <= PH_HIGH;
            end
         end

`ifdef LCD_RESP_READ_EN
         if (xfer && rw_s2 && rs_s2 && (!mode4 || low_phase))
            ac <= ac_step(ac, cursor_incr);
`endif

         if (byte_done) begin
            cmd_rs   <= rs_s2;
            cmd_byte <= new_byte;
            if (busy) begin
               overrun <= 1'b1;
            end else if (rs_s2) begin
               if (ac_visible(ac)) begin
                  if (ac[6])
                     row_b[{~ac[3:0], 3'b000} +: 8] <= new_byte;
                  else
                     row_a[{~ac[3:0], 3'b000} +: 8] <= new_byte;
               end
               ac       <= ac_step(ac, cursor_incr);
               busy_cnt <= EXEC_LOAD;
            end else begin
               busy_cnt <= EXEC_LOAD;
               casez (new_byte)
                  8'b1???????: ac <= set_ac_value(new_byte[6:0]);
                  8'b001?????: begin
                     mode4 <= ~new_byte[4];
                     phase <= PH_HIGH;
                  end
                  8'b00001???: display_on  <= new_byte[2];
                  8'b000001??: cursor_incr <= new_byte[1];
                  8'b0000001?: begin
                     ac       <= 7'h00;
                     busy_cnt <= CLEAR_LOAD;
                  end
                  8'b00000001: begin
                     row_a       <= BLANK_ROW;
                     row_b       <= BLANK_ROW;
                     ac          <= 7'h00;
                     cursor_incr <= 1'b1;
                     busy_cnt    <= CLEAR_LOAD;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef LCD_RESP_READ_EN
   logic [7:0] read_char;
   logic       rd_high;

   // Character under the address counter; hidden cells read as a space.
   always_comb begin
      read_char = 8'h20;
      if (ac_visible(ac))
         read_char = ac[6] ? row_b[{~ac[3:0], 3'b000} +: 8]
                           : row_a[{~ac[3:0], 3'b000} +: 8];
      rd_high = !mode4 || (phase == PH_HIGH);
   end

   // Read-back driver: valid while the host holds E high with RW=1.
   always_ff @(posedge clk) begin
      if (reset) begin
         lcd_doe  <= 1'b0;
         lcd_dout <= 4'h0;
      end else begin
         lcd_doe <= e_s2 & rw_s2;
         if (!rs_s2)
            lcd_dout <= rd_high ? {busy, ac[6:4]} : ac[3:0];
         else
            lcd_dout <= rd_high ? read_char[7:4] : read_char[3:0];
      end
   end
`else
   assign lcd_doe  = 1'b0;
   assign lcd_dout = 4'h0;
`endif

endmodule

// File: tb/tb_lcd1602_responder.sv
// ---------------------------------------------------------------------------
// tb_lcd1602_responder
//
// Drives the LCD host bus with directed sequences followed by randomised
// traffic and compares every observable output against a reference model of
// the controller kept as a DDRAM byte array and a few scalars. The busy timer
// is modelled as an absolute end cycle rather than a countdown.
// ---------------------------------------------------------------------------
module tb_lcd1602_responder;

   localparam int CLR = 300;
   localparam int EXE = 37;

   logic         clk = 1'b0;
   logic         reset;
   logic         lcdE, lcdRs, lcdRw;
   logic [3:0]   lcdD;
   logic [127:0] rowA, rowB;
   logic [6:0]   acOut;
   logic         mode4, displayOn, cursorIncr, busy, overrun;
   logic         cmdValid, cmdRs;
   logic [7:0]   cmdByte;
   logic [3:0]   lcdDout;
   logic         lcdDoe;

   lcd1602_responder #(
      .CLEAR_CYCLES(CLR),
      .EXEC_CYCLES (EXE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .lcd_e      (lcdE),
      .lcd_rs     (lcdRs),
      .lcd_rw     (lcdRw),
      .lcd_d      (lcdD),
      .row_a      (rowA),
      .row_b      (rowB),
      .ac         (acOut),
      .mode4      (mode4),
      .display_on (displayOn),
      .cursor_incr(cursorIncr),
      .busy       (busy),
      .overrun    (overrun),
      .cmd_valid  (cmdValid),
      .cmd_rs     (cmdRs),
      .cmd_byte   (cmdByte),
      .lcd_dout   (lcdDout),
      .lcd_doe    (lcdDoe)
   );

   always #5 clk = ~clk;

   // Edge counter: after the Nth rising edge cyc == N
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pulseCount = 0;
   always @(negedge clk) if (cmdValid) pulseCount <= pulseCount + 1;

   int checks = 0;
   int passed = 0;

   // Reference model
   logic [7:0] mDdram [0:127];
   int         mAc;
   bit         mMode4, mPhaseHigh, mDisp, mIncr, mOverrun, mValid, mCmdRs;
   logic [7:0] mCmdByte;
   logic [3:0] mHi;
   int         mBusyEnd;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      else
         passed++;
   endtask

   function automatic int acStep(input int a, input bit incr);
      if (incr) begin
         if (a == 'h27) return 'h40;
         if (a == 'h67) return 0;
         return a + 1;
      end
      if (a == 0) return 'h67;
      if (a == 'h40) return 'h27;
      return a - 1;
   endfunction

   function automatic bit isVisible(input int a);
      return (a < 16) || (a >= 64 && a < 80);
   endfunction

   function automatic logic [127:0] rowImage(input int base);
      logic [127:0] img;
      for (int i = 0; i < 16; i++) img[127-8*i -: 8] = mDdram[base+i];
      return img;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 128; i++) mDdram[i] = 8'h20;
      mAc = 0; mMode4 = 0; mPhaseHigh = 1; mDisp = 0; mIncr = 1;
      mOverrun = 0; mValid = 0; mCmdRs = 0; mCmdByte = 8'h00; mHi = 4'h0;
      mBusyEnd = 0;
   endtask

   task automatic modelExecute(input bit rs, input logic [7:0] b, input int u);
      int n;
      int v;
      n = EXE;
      if (rs) begin
         if (isVisible(mAc)) mDdram[mAc] = b;
         mAc = acStep(mAc, mIncr);
      end else if (b >= 128) begin
         v = b - 128;
         if (v >= 40 && v < 64) v = 64;
         else if (v >= 104) v = 0;
         mAc = v;
      end else if (b >= 64) begin
      end else if (b >= 32) begin
         mMode4 = (b & 8'h10) == 0;
         mPhaseHigh = 1;
      end else if (b >= 16) begin
      end else if (b >= 8) begin
         mDisp = (b & 8'h04) != 0;
      end else if (b >= 4) begin
         mIncr = (b & 8'h02) != 0;
      end else if (b >= 2) begin
         mAc = 0; n = CLR;
      end else if (b == 1) begin
         for (int i = 0; i < 128; i++) mDdram[i] = 8'h20;
         mAc = 0; mIncr = 1; n = CLR;
      end
      mBusyEnd = u + n;
   endtask

   // One bus transfer whose effects appear after edge u
   task automatic modelXfer(input bit rs, input bit rw, input logic [3:0] d, input int u);
      bit lowPhase;
      bit done;
      logic [7:0] b;
      lowPhase = mMode4 && !mPhaseHigh;
      done = 0;
      b = 8'h00;
      mValid = 0;
      if (mMode4) begin
         if (mPhaseHigh) mHi = d;
         mPhaseHigh = !mPhaseHigh;
      end
      if (rw) begin
`ifdef LCD_RESP_READ_EN
         if (rs && (!mMode4 || lowPhase)) mAc = acStep(mAc, mIncr);
`endif
      end else if (!mMode4) begin
         done = 1; b = {d, 4'h0};
      end else if (lowPhase) begin
         done = 1; b = {mHi, d};
      end
      if (done) begin
         mValid = 1; mCmdRs = rs; mCmdByte = b;
         if (u <= mBusyEnd) mOverrun = 1;
         else modelExecute(rs, b, u);
      end
   endtask

   task automatic checkState();
      checkOutput("ac", acOut, mAc);
      checkOutput("mode4", mode4, mMode4);
      checkOutput("display_on", displayOn, mDisp);
      checkOutput("cursor_incr", cursorIncr, mIncr);
      checkOutput("overrun", overrun, mOverrun);
      checkOutput("busy", busy, cyc < mBusyEnd);
      checkOutput("row_a", rowA, rowImage(0));
      checkOutput("row_b", rowB, rowImage(64));
      checkOutput("cmd_valid", cmdValid, mValid);
      checkOutput("cmd_rs", cmdRs, mCmdRs);
      checkOutput("cmd_byte", cmdByte, mCmdByte);
      checkOutput("lcd_doe", lcdDoe, 1'b0);
`ifndef LCD_RESP_READ_EN
      checkOutput("lcd_dout", lcdDout, 4'h0);
`endif
   endtask

   // Read-back expectation while E is held high; the driver registers
   // its value from the state present one cycle earlier.
   task automatic checkReadback(input bit rs);
      int expNib;
      int ch;
      bit hiPhase;
      bit busyPrev;
      hiPhase  = !mMode4 || mPhaseHigh;
      busyPrev = (cyc - 1) < mBusyEnd;
      ch = isVisible(mAc) ? int'(mDdram[mAc]) : 'h20;
      if (!rs) expNib = hiPhase ? (busyPrev * 8 + mAc / 16) : (mAc % 16);
      else     expNib = hiPhase ? (ch / 16) : (ch % 16);
`ifdef LCD_RESP_READ_EN
      checkOutput("rd_doe", lcdDoe, 1'b1);
      checkOutput("rd_dout", lcdDout, expNib);
`else
      checkOutput("rd_doe", lcdDoe, 1'b0);
      checkOutput("rd_dout", lcdDout, 4'h0);
`endif
   endtask

   // One host transfer: raise E, hold, drop E, then check the update
   // three edges later and the end of the cmd_valid pulse one edge after.
   task automatic applyStimulus(input bit rs, input bit rw, input logic [3:0] d);
      int hc;
      int u;
      hc = $urandom_range(4, 7);
      lcdRs = rs; lcdRw = rw; lcdD = d; lcdE = 1'b1;
      repeat (hc) @(negedge clk);
      if (rw) checkReadback(rs);
      lcdE = 1'b0;
      u = cyc + 3;
      modelXfer(rs, rw, d, u);
      repeat (3) @(negedge clk);
      checkState();
      @(negedge clk);
      checkOutput("cmd_valid_drop", cmdValid, 1'b0);
      mValid = 0;
   endtask

   task automatic sendByte(input bit rs, input logic [7:0] b);
      if (mMode4) begin
         applyStimulus(rs, 1'b0, b[7:4]);
         applyStimulus(rs, 1'b0, b[3:0]);
      end else begin
         applyStimulus(rs, 1'b0, b[7:4]);
      end
   endtask

   task automatic readPair(input bit rs);
      logic [3:0] junk;
      junk = 4'($urandom);
      applyStimulus(rs, 1'b1, junk);
      junk = 4'($urandom);
      applyStimulus(rs, 1'b1, junk);
   endtask

   // Wait out the busy timer, checking its last busy cycle and first idle one
   task automatic waitIdle();
      if (cyc < mBusyEnd) begin
         while (cyc < mBusyEnd - 1) @(negedge clk);
         checkOutput("busy_last", busy, 1'b1);
         @(negedge clk);
      end
      checkOutput("busy_done", busy, 1'b0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      lcdE = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      modelReset();
   endtask

   initial begin
      int r;
      int startPulses;
      logic [7:0] b;
      reset = 1'b1; lcdE = 1'b0; lcdRs = 1'b0; lcdRw = 1'b0; lcdD = 4'h0;
      @(negedge clk);
      doReset();

      // Reset state
      checkState();
      checkOutput("reset_dout", lcdDout, 4'h0);
      checkOutput("reset_doe", lcdDoe, 1'b0);
      checkOutput("reset_row_a", rowA, {16{8'h20}});

      // Initialisation nibbles 3,3,3,2 into 4-bit mode
      startPulses = pulseCount;
      sendByte(0, 8'h30); waitIdle();
      sendByte(0, 8'h30); waitIdle();
      sendByte(0, 8'h30); waitIdle();
      checkOutput("still_8bit", mode4, 1'b0);
      sendByte(0, 8'h20); waitIdle();
      checkOutput("init_mode4", mode4, 1'b1);
      checkOutput("init_cmd_byte", cmdByte, 8'h20);
      checkOutput("init_pulses", pulseCount - startPulses, 4);

      // First characters on line one
      sendByte(0, 8'h0C); waitIdle();
      sendByte(0, 8'h80); waitIdle();
      sendByte(1, 8'h41); waitIdle();
      sendByte(1, 8'h42); waitIdle();
      checkOutput("row_a_AB", rowA[127:112], 16'h4142);
      checkOutput("ac_after_AB", acOut, 7'h02);

      // Address wrap and hidden-cell write
      sendByte(0, 8'hA7); waitIdle();
      sendByte(1, 8'h5A); waitIdle();
      checkOutput("ac_wrap_27", acOut, 7'h40);
      checkOutput("hidden_row_b", rowB, {16{8'h20}});
      sendByte(0, 8'h04); waitIdle();
      sendByte(0, 8'h80); waitIdle();
      sendByte(1, 8'h33); waitIdle();
      checkOutput("ac_dec_wrap", acOut, 7'h67);
      checkOutput("dec_char", rowA[127:120], 8'h33);
      sendByte(0, 8'h06); waitIdle();
      sendByte(0, 8'hAB); waitIdle();
      checkOutput("set_ac_hole1", acOut, 7'h40);
      sendByte(0, 8'hF0); waitIdle();
      checkOutput("set_ac_hole2", acOut, 7'h00);

      // Read-back of the address counter and of DDRAM
      sendByte(0, 8'hC5); waitIdle();
      readPair(0);
      sendByte(0, 8'hC0); waitIdle();
      sendByte(1, 8'h51); waitIdle();
      sendByte(0, 8'hC0); waitIdle();
      readPair(1);
`ifdef LCD_RESP_READ_EN
      checkOutput("read_ac_adv", acOut, 7'h41);
`else
      checkOutput("read_ac_adv", acOut, 7'h40);
`endif

      // Write while clear is still executing
      checkOutput("no_overrun_yet", overrun, 1'b0);
      sendByte(0, 8'h01);
      repeat (80) @(negedge clk);
      sendByte(1, 8'h58);
      checkOutput("clear_overrun", overrun, 1'b1);
      checkOutput("clear_row_a", rowA, {16{8'h20}});
      checkOutput("clear_busy", busy, 1'b1);
      waitIdle();

      // Reset mid-busy and mid-byte
      sendByte(0, 8'h02);
      applyStimulus(0, 1'b0, 4'h8);
      doReset();
      checkState();
      applyStimulus(0, 1'b0, 4'h3);
      checkOutput("post_reset_byte", cmdByte, 8'h30);
      waitIdle();
      sendByte(0, 8'h20); waitIdle();

      // Randomised traffic in 4-bit mode
      for (int it = 0; it < 70; it++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      begin b = 8'($urandom_range(32, 126)); sendByte(1, b); end
         else if (r < 50) begin b = 8'h80 | 8'($urandom_range(0, 127)); sendByte(0, b); end
         else if (r < 58) begin b = 8'h04 | 8'($urandom_range(0, 3)); sendByte(0, b); end
         else if (r < 64) begin b = 8'h08 | 8'($urandom_range(0, 7)); sendByte(0, b); end
         else if (r < 68) sendByte(0, 8'h02);
         else if (r < 71) sendByte(0, 8'h01);
         else if (r < 76) begin b = 8'h20 | 8'($urandom_range(0, 15)); sendByte(0, b); end
         else if (r < 90) readPair(1'($urandom));
         else             begin b = 8'h10 | 8'($urandom_range(0, 15)); sendByte(0, b); end
         if ($urandom_range(0, 1) == 0) waitIdle();
         else repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      waitIdle();
      checkState();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
